// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/redirect controller for a 5-stage, non-forwarding pipeline.
// A 3-slot destination scoreboard drives stalls; MEM-resolved redirects squash the wrong path.
module pipeline_hazard_ctrl #(
  parameter int WB_BYPASS = 0,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       IDRs,
  input  logic [4:0]       IDRt,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic             IDRegWrite,
  input  logic [4:0]       IDDest,
  input  logic             MEMBranchTaken,
  input  logic             MEMJump,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             EXMEMFlush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int SLOTS    = 3;
  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  logic [SLOTS-1:0] sb_valid_reg;
  logic [SLOTS-1:0] sb_valid_next;
  logic [4:0]       sb_dest_reg  [SLOTS];
  logic [4:0]       sb_dest_next [SLOTS];

  logic [SLOTS-1:0] rs_hit;
  logic [SLOTS-1:0] rt_hit;
  logic             rs_hazard;
  logic             rt_hazard;
  logic             hazard;
  logic             redirect;
  logic             stall;

  logic [CNT_W-1:0] stall_count_reg;
  logic [CNT_W-1:0] stall_count_next;
  logic [CNT_W-1:0] flush_count_reg;
  logic [CNT_W-1:0] flush_count_next;

  // With a write-through register file the WB slot can never cause a hazard.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot_cmp
      localparam bit CHECKED = (gi != SLOT_WB) || (WB_BYPASS == 0);
      assign rs_hit[gi] = CHECKED && sb_valid_reg[gi] && (sb_dest_reg[gi] == IDRs);
      assign rt_hit[gi] = CHECKED && sb_valid_reg[gi] && (sb_dest_reg[gi] == IDRt);
    end
  endgenerate

  assign rs_hazard = IDUsesRs && (IDRs != 5'd0) && (|rs_hit);
  assign rt_hazard = IDUsesRt && (IDRt != 5'd0) && (|rt_hit);
  assign hazard    = rs_hazard || rt_hazard;
  assign redirect  = MEMBranchTaken || MEMJump;
  // The ID instruction is squashed on a redirect, so it must not also stall.
  assign stall     = hazard && !redirect;

  always_comb begin
    PCWrite    = !stall;
    IFIDWrite  = !stall;
    IFIDFlush  = redirect;
    IDEXBubble = stall || redirect;
    EXMEMFlush = redirect;
    if (RST) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      EXMEMFlush = 1'b1;
    end
  end

  always_comb begin
    sb_valid_next          = sb_valid_reg;
    sb_dest_next[SLOT_EX]  = sb_dest_reg[SLOT_EX];
    sb_dest_next[SLOT_MEM] = sb_dest_reg[SLOT_MEM];
    sb_dest_next[SLOT_WB]  = sb_dest_reg[SLOT_WB];

    sb_valid_next[SLOT_WB] = sb_valid_reg[SLOT_MEM];
    sb_dest_next[SLOT_WB]  = sb_dest_reg[SLOT_MEM];

    sb_valid_next[SLOT_MEM] = sb_valid_reg[SLOT_EX] && !redirect;
    sb_dest_next[SLOT_MEM]  = sb_dest_reg[SLOT_EX];

    // r0 writes are architecturally discarded, so they never occupy a slot.
    sb_valid_next[SLOT_EX] = !stall && !redirect && IDRegWrite && (IDDest != 5'd0);
    sb_dest_next[SLOT_EX]  = IDDest;
  end

  always_comb begin
    stall_count_next = stall_count_reg;
    flush_count_next = flush_count_reg;
    if (stall && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_next = stall_count_reg + CNT_W'(1);
    end
    if (redirect && (flush_count_reg != {CNT_W{1'b1}})) begin
      flush_count_next = flush_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sb_valid_reg    <= '0;
      stall_count_reg <= '0;
      flush_count_reg <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        sb_dest_reg[i] <= 5'd0;
      end
    end else begin
      sb_valid_reg    <= sb_valid_next;
      stall_count_reg <= stall_count_next;
      flush_count_reg <= flush_count_next;
      for (int i = 0; i < SLOTS; i++) begin
        sb_dest_reg[i] <= sb_dest_next[i];
      end
    end
  end

  assign StallCount = stall_count_reg;
  assign FlushCount = flush_count_reg;

endmodule
